// File: rtl/fpga_prog_ctrl.sv
// FPGA configuration load controller.
// Streams host bitstream words into the fabric programming lines one word per
// accepted handshake. It then verifies a trailing XOR checksum word. Fabric
// data is enabled only while a verified configuration is held.
module fpga_prog_ctrl #(
    parameter int V        = 2,
    parameter int H        = 2,
    parameter int CB_WORDS = 2*V+1,
    parameter int LL_WORDS = 2*V+2
) (
    input  logic          clk,
    input  logic          nres,
    input  logic          start,
    input  logic          abort,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [31:0]   cfg_data,
    input  logic          user_en,
    output logic [31:0]   prog_i,
    output logic [2*H:0]  prog_shft,
    output logic          data_en,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int NL   = 2*H+1;
    localparam int LW   = $clog2(NL+1);
    localparam int MAXW = (CB_WORDS > LL_WORDS) ? CB_WORDS : LL_WORDS;
    localparam int WW   = $clog2(MAXW+1);

    localparam logic [LW-1:0] LAST_LINE = LW'(2*H);
    localparam logic [WW-1:0] CB_LAST   = WW'(CB_WORDS-1);
    localparam logic [WW-1:0] LL_LAST   = WW'(LL_WORDS-1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;

    state_t          state_q;
    logic [LW-1:0]   line_q;
    logic [WW-1:0]   word_q;
    logic [31:0]     acc_q;
    logic [31:0]     prog_q;
    logic [NL-1:0]   shft_q;
    logic            done_q;
    logic            error_q;
    logic            data_en_q;

    logic            accept;
    logic            word_wrap;
    logic [WW-1:0]   word_end;
    logic [WW-1:0]   word_d;
    logic [LW-1:0]   line_d;
    logic [31:0]     acc_d;
    logic [NL-1:0]   shft_d;

    assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign cfg_ready = busy;
    assign accept    = cfg_valid && cfg_ready;

    // Next values of the line/word position, checksum and one-hot strobe.
    // Even lines are crossbar lines, odd lines are logic lines.
    always_comb begin
        word_end  = line_q[0] ? LL_LAST : CB_LAST;
        word_wrap = (word_q == word_end);
        word_d    = word_wrap ? '0 : word_q + 1'b1;
        line_d    = word_wrap ? line_q + 1'b1 : line_q;
        acc_d     = acc_q ^ cfg_data;
        shft_d    = NL'(1) << line_q;
    end

    // Load sequencer with registered fabric-side outputs; strobes last one cycle.
    always_ff @(posedge clk) begin
        if (nres) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            word_q    <= '0;
            acc_q     <= '0;
            prog_q    <= '0;
            shft_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            data_en_q <= 1'b0;
        end else begin
            shft_q <= '0;
            // done is only ever set in DONE, and start in DONE drops it on the
            // same edge, so the enable drops together with done.
            data_en_q <= user_en && done_q && !start;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        line_q  <= '0;
                        word_q  <= '0;
                        acc_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else if (accept) begin
                        prog_q <= cfg_data;
                        shft_q <= shft_d;
                        acc_q  <= acc_d;
                        word_q <= word_d;
                        if (word_wrap && (line_q == LAST_LINE)) begin
                            state_q <= S_CHECK;
                        end else begin
                            line_q <= line_d;
                        end
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else if (accept) begin
                        if (cfg_data == acc_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prog_i    = prog_q;
    assign prog_shft = shft_q;
    assign done      = done_q;
    assign error     = error_q;
    assign data_en   = data_en_q;

endmodule

// File: tb/tb_fpga_prog_ctrl.sv
// Directed bench for fpga_prog_ctrl with V=1, H=1 (3 lines, 10 data words).
module tb_fpga_prog_ctrl;

    logic        clk;
    logic        nres;
    logic        start;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        user_en;
    logic [31:0] prog_i;
    logic [2:0]  prog_shft;
    logic        data_en;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [2:0]  log_shft [$];
    logic [31:0] log_data [$];

    // Strobe pattern of a complete load: 3 words line 0, 4 words line 1, 3 words line 2.
    logic [2:0] exp_shft [10] = '{3'b001, 3'b001, 3'b001,
                                  3'b010, 3'b010, 3'b010, 3'b010,
                                  3'b100, 3'b100, 3'b100};

    fpga_prog_ctrl #(.V(1), .H(1)) dut (
        .clk       (clk),
        .nres      (nres),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .user_en   (user_en),
        .prog_i    (prog_i),
        .prog_shft (prog_shft),
        .data_en   (data_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every strobe seen, sampled mid-cycle.
    always @(negedge clk) begin
        if (prog_shft != 3'b000) begin
            log_shft.push_back(prog_shft);
            log_data.push_back(prog_i);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] chk, input bit gap);
        for (int i = 1; i <= 10; i++) begin
            send(32'(i));
            if (gap) tick();
        end
        send(chk);
    endtask

    task automatic check_log(input string tag, input int n);
        check({tag, "_count"}, 64'(log_shft.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < log_shft.size()) begin
                check({tag, "_shft"}, 64'(log_shft[i]), 64'(exp_shft[i]));
                check({tag, "_data"}, 64'(log_data[i]), 64'(i + 1));
            end
        end
    endtask

    task automatic clear_log();
        log_shft.delete();
        log_data.delete();
    endtask

    initial begin
        nres      = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        user_en   = 1'b0;
        tick();
        tick();
        check("reset_outputs", 64'({prog_i, prog_shft, cfg_ready, data_en, busy, done, error}), 64'd0);
        nres = 1'b0;
        tick();
        check("idle_ready", 64'(cfg_ready), 64'd0);

        // Abort and stray words in IDLE are ignored; start wins over abort.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("start_wins_busy", 64'(busy), 64'd1);
        check("start_wins_err", 64'(error), 64'd0);
        check("load_ready", 64'(cfg_ready), 64'd1);

        // Full load with good checksum.
        clear_log();
        load(32'h0000000B, 1'b0);
        check_log("full", 10);
        check("full_done", 64'({done, error, busy, cfg_ready}), 64'b1000);
        check("full_hold", 64'(prog_i), 64'd10);
        check("full_noshft", 64'(prog_shft), 64'd0);

        // Abort in DONE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("done_abort", 64'({done, error}), 64'b10);

        // Gating of data_en in DONE.
        user_en = 1'b1;
        tick();
        check("gate_on", 64'(data_en), 64'd1);
        user_en = 1'b0;
        tick();
        check("gate_off", 64'(data_en), 64'd0);
        user_en = 1'b1;
        tick();
        check("gate_on2", 64'(data_en), 64'd1);
        pulse_start();
        check("start_clears", 64'({done, data_en, busy}), 64'b001);

        // Bad checksum on the load just started.
        clear_log();
        load(32'h0000000C, 1'b0);
        check_log("badchk", 10);
        check("badchk_flags", 64'({done, error, busy}), 64'b010);
        tick();
        tick();
        check("badchk_gate", 64'(data_en), 64'd0);
        user_en = 1'b0;

        // Backpressure: valid every other cycle.
        pulse_start();
        check("bp_clear_err", 64'(error), 64'd0);
        clear_log();
        load(32'h0000000B, 1'b1);
        check_log("bp", 10);
        check("bp_done", 64'({done, error}), 64'b10);

        // Abort presented with word 5.
        pulse_start();
        clear_log();
        for (int i = 1; i <= 4; i++) send(32'(i));
        cfg_valid = 1'b1;
        cfg_data  = 32'd5;
        abort     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        check("abort_flags", 64'({done, error, busy, cfg_ready}), 64'b0100);
        check("abort_noshft", 64'(prog_shft), 64'd0);
        tick();
        tick();
        check_log("abort", 4);
        check("abort_prog_i", 64'(prog_i), 64'd4);

        // Reset mid-load, then a fresh full load.
        pulse_start();
        clear_log();
        for (int i = 1; i <= 6; i++) send(32'(i));
        nres = 1'b1;
        tick();
        check("midreset_outputs", 64'({prog_i, prog_shft, cfg_ready, data_en, busy, done, error}), 64'd0);
        nres = 1'b0;
        check_log("midreset", 6);
        send(32'd7);
        tick();
        check("midreset_nostrobe", 64'(log_shft.size()), 64'd6);
        clear_log();
        pulse_start();
        load(32'h0000000B, 1'b0);
        check_log("reload", 10);
        check("reload_done", 64'({done, error}), 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_prog_ctrl.md
FPGA_PROG_CTRL -- requirements
Module: fpga_prog_ctrl

Interface
REQ-001 Parameter V, default 2: logic columns per line, same meaning as in the fabric.
REQ-002 Parameter H, default 2: logic rows; the fabric has 2H+1 programming lines, numbered 0..2H.
REQ-003 Parameter CB_WORDS, default 2*V+1: 32-bit words shifted into each even (crossbar) line.
REQ-004 Parameter LL_WORDS, default 2*V+2: 32-bit words shifted into each odd (input-logic plus logic) line.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port nres, input, 1: reset, synchronous and active-high (1 = reset).
REQ-007 Port start, input, 1: pulse that begins a configuration load.
REQ-008 Port abort, input, 1: pulse that cancels a load in progress.
REQ-009 Port cfg_valid, input, 1: host word valid.
REQ-010 Port cfg_ready, output, 1: controller accepts a word this cycle.
REQ-011 Port cfg_data, input, 32: host bitstream word.
REQ-012 Port user_en, input, 1: user data enable request.
REQ-013 Port prog_i, output, 32: word to the fabric programming chains.
REQ-014 Port prog_shft, output, 2H+1: per-line shift strobe; bit n drives line n.
REQ-015 Port data_en, output, 1: gated data enable to the fabric.
REQ-016 Port busy, output, 1: load in progress (LOAD or CHECK).
REQ-017 Port done, output, 1: fabric holds a verified configuration.
REQ-018 Port error, output, 1: last load failed its checksum or was aborted.

Function
REQ-019 The controller SHALL implement states IDLE, LOAD, CHECK, DONE and ERR.
REQ-020 IDLE/DONE/ERR: start=1 -> LOAD; clear done, error, line index, word count and checksum accumulator.
REQ-021 start SHALL be ignored in LOAD and CHECK.
REQ-022 cfg_ready SHALL be 1 only in LOAD and CHECK; a word is accepted on cfg_valid && cfg_ready.
REQ-023 Each word accepted in LOAD SHALL, on the next cycle only, set prog_i=cfg_data and make prog_shft one-hot at the current line index.
REQ-024 In cycles with no accepted word, prog_shft SHALL be all zeros; prog_i SHALL hold its last value.
REQ-025 The word counter SHALL increment per accepted word. At CB_WORDS-1 (even line) or LL_WORDS-1 (odd line) it wraps to 0 and the line index increments.
REQ-026 When the last word of line 2H is accepted, the state SHALL go to CHECK; no further strobe is issued.
REQ-027 The checksum accumulator SHALL be the 32-bit XOR of all words accepted in LOAD.
REQ-028 In CHECK, one accepted word SHALL be compared with the accumulator: equal -> DONE with done=1; unequal -> ERR with error=1. The checksum word is never strobed into the fabric.
REQ-029 abort=1 in LOAD or CHECK SHALL go to ERR with error=1 and prog_shft=0 from the next cycle; a word accepted in the same cycle is discarded (no strobe).
REQ-030 abort in IDLE, DONE or ERR SHALL be ignored; if start and abort are both 1 in IDLE, start wins.
REQ-031 data_en SHALL equal user_en && done, registered with 1-cycle latency.
REQ-032 busy SHALL be 1 exactly in LOAD and CHECK.
REQ-033 Total load length SHALL be (H+1)*CB_WORDS + H*LL_WORDS data words plus 1 checksum word.

Reset
REQ-034 With nres=1 at a clock edge: state=IDLE; prog_i=0, prog_shft=0, cfg_ready=0, data_en=0, busy=0, done=0, error=0; counters and accumulator=0.
REQ-035 Reset mid-load SHALL take effect on that edge, issue no further strobe, and require a new start.

Verification (V=1, H=1: CB_WORDS=3, LL_WORDS=4, 10 data words)
REQ-036 Full load:
- Stimulus: start, then words 1..10 back-to-back, then checksum 0x0000000B.
- Response: strobe pattern 001 x3, 010 x4, 100 x3; prog_i echoes 1..10; done=1, error=0.
REQ-037 Bad checksum:
- Stimulus: the same stream with checksum 0x0000000C.
- Response: error=1, done=0; data_en stays 0 with user_en=1.
REQ-038 Backpressure:
- Stimulus: cfg_valid toggled every other cycle.
- Response: one strobe per accepted word only; same final strobe and prog_i sequence as REQ-036.
REQ-039 Abort:
- Stimulus: abort asserted on the cycle word 5 is presented.
- Response: error=1; word 5 is not strobed; only 4 strobes total.
REQ-040 Reset mid-load:
- Stimulus: nres=1 after word 6, then a new start and a full load.
- Response: all outputs 0 after the reset edge; the reload strobes from line 0, word 0, and ends with done=1.
REQ-041 Gating:
- Stimulus: in DONE, toggle user_en.
- Response: data_en follows user_en one cycle later; start clears done and forces data_en=0.
